axi_store_unit: RTL and testbench
=================================

AXI_STORE_UNIT -- requirements
Module: axi_store_unit

Interface
REQ-001 The block SHALL have parameter ID_WIDTH, default 13, AXI ID width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 64, address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 64, bus data width.
REQ-004 The block SHALL have parameter STORE_ID, default 1, constant value driven on m_axi_awid.
REQ-005 The block SHALL have these ports, plus the AXI constant ports in REQ-008, and use one clock with an asynchronous, active-low reset:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  request accepted when st_valid && st_ready.
- st_addr  in  ADDR_WIDTH  byte address.
- st_data  in  DATA_WIDTH  store data, right-justified.
- st_size  in  2  0 byte, 1 half, 2 word, 3 dword.
- st_done  out  1  one-cycle completion pulse.
- st_err  out  1  valid with st_done; 1 = misaligned or bus error.
- m_axi_awaddr  out  ADDR_WIDTH  write address.
- m_axi_awvalid / m_axi_awready  out/in  1  AW handshake.
- m_axi_wdata  out  DATA_WIDTH  lane-aligned data.
- m_axi_wstrb  out  DATA_WIDTH/8  byte strobes.
- m_axi_wlast  out  1  last beat.
- m_axi_wvalid / m_axi_wready  out/in  1  W handshake.
- m_axi_bid  in  ID_WIDTH  response ID.
- m_axi_bresp  in  2  response code.
- m_axi_bvalid / m_axi_bready  in/out  1  B handshake.

Function
REQ-006 The FSM SHALL have four states: IDLE, MISALIGN, SEND, RESP; st_ready=1 only in IDLE.
REQ-007 Accept in IDLE SHALL register addr/data/size; aligned (addr mod 2^size == 0) -> SEND, else -> MISALIGN.
REQ-008 AXI constants SHALL be: m_axi_awid=STORE_ID, m_axi_awlen=0, m_axi_awsize={1'b0,st_size}, m_axi_awburst=2'b01, m_axi_awlock=0, m_axi_awcache=0, m_axi_awprot=0, m_axi_wlast=m_axi_wvalid.
REQ-009 MISALIGN SHALL last one cycle, assert st_done=1 and st_err=1, issue no AXI traffic, and then go to IDLE.
REQ-010 On entering SEND, awvalid and wvalid SHALL both rise in the cycle after acceptance, both registered.
REQ-011 awvalid SHALL hold, with awaddr stable, until awready is sampled high, and SHALL deassert the following cycle.
REQ-012 wvalid SHALL hold independently until wready is sampled high, and SHALL deassert the following cycle; AW and W completion order is arbitrary, and same-cycle completion SHALL be legal.
REQ-013 SEND SHALL go to RESP once both handshakes are done; bready SHALL be 1 only in RESP.
REQ-014 The B handshake in RESP SHALL go to IDLE with st_done=1 in the next cycle; st_err SHALL equal bresp[1] OR (bid != STORE_ID).
REQ-015 wstrb SHALL be ((1<<(1<<size))-1) << addr[2:0], and dword SHALL give 8'hFF.
REQ-016 wdata SHALL be st_data << (8*addr[2:0]), truncated to DATA_WIDTH.
REQ-017 awaddr SHALL be the unmodified captured address.
REQ-018 st_done SHALL be high exactly one cycle per accepted request; a new request MAY be accepted in the same cycle that st_done is high.
REQ-019 The block SHALL have at most one outstanding transaction, and SHALL ignore bvalid outside RESP.

Reset
REQ-020 Asserting reset (low) SHALL immediately force IDLE, awvalid=0, wvalid=0, bready=0, st_done=0, st_err=0, st_ready=1, and clear captured registers to 0.
REQ-021 Reset asserted mid-transaction SHALL abandon the transaction; after deassertion no stale response SHALL produce st_done.
REQ-022 Reset deassertion SHALL be synchronised to clk, with the first accept possible on the second rising edge after deassertion.

Verification
REQ-023 Dword store: addr 0x1000, data 0x1122334455667788, size 3, AW/W/B ready immediately -> awaddr 0x1000, wstrb 0xFF, wdata equals data, st_done one cycle after B, st_err=0.
REQ-024 Byte store: addr 0x2005, data 0xAB, size 0 -> wstrb 0x20, wdata[47:40]=0xAB, awsize 0.
REQ-025 Misaligned: addr 0x3002, size 2 -> no awvalid/wvalid ever, st_done=st_err=1 two cycles after accept.
REQ-026 Skewed ready: wready at cycle 1, awready at cycle 5, bvalid with bresp=2'b10 at cycle 8 -> wvalid drops after cycle 1, awvalid held to 5, st_err=1.
REQ-027 Reset low while in RESP, then a late bvalid after release -> no st_done, st_ready=1, all valids 0.
REQ-028 Back-to-back: second st_valid held during first -> accepted in the st_done cycle, and both complete in order.

Source files
------------

// File: rtl/axi_store_unit.sv
// axi_store_unit: turns one store request (address, right-justified data, size)
// into a single-beat AXI write. Misaligned requests complete with an error and
// issue no bus traffic. At most one transaction is in flight at a time.
module axi_store_unit #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int STORE_ID   = 1
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [ADDR_WIDTH-1:0]   st_addr,
  input  logic [DATA_WIDTH-1:0]   st_data,
  input  logic [1:0]              st_size,
  output logic                    st_done,
  output logic                    st_err,

  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,

  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,

  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, MISALIGN, SEND, RESP} state_t;

  state_t                  state;
  logic                    rst_sync;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [1:0]              size_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    bready_q;
  logic                    done_q;
  logic                    err_q;
  logic                    misalign;
  logic                    resp_err;
  logic [STRB_W-1:0]       lane_mask;

  // Reset asserts immediately but releases on a clock edge; the core leaves
  // reset one edge after deassertion, so the first accept is on the second edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 1'b0;
    else        rst_sync <= 1'b1;
  end

  // Natural alignment check of the incoming request address against its size
  always_comb begin
    misalign = 1'b0;
    case (st_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = st_addr[0];
      2'd2:    misalign = |st_addr[1:0];
      default: misalign = |st_addr[2:0];
    endcase
  end

  // Unshifted byte-lane mask for the captured access size
  always_comb begin
    lane_mask = '0;
    case (size_q)
      2'd0:    lane_mask[0]   = 1'b1;
      2'd1:    lane_mask[1:0] = '1;
      2'd2:    lane_mask[3:0] = '1;
      default: lane_mask[7:0] = '1;
    endcase
  end

  // SLVERR and DECERR both have bresp[1] set
  assign resp_err = (m_axi_bresp inside {2'b10, 2'b11});

  // Request FSM: capture, AW/W issue with independent completion, B collect
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      size_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (st_valid) begin
            addr_q <= st_addr;
            data_q <= st_data;
            size_q <= st_size;
            if (misalign) begin
              state <= MISALIGN;
            end else begin
              state     <= SEND;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end
          end
        end
        MISALIGN: begin
          done_q <= 1'b1;
          err_q  <= 1'b1;
          state  <= IDLE;
        end
        SEND: begin
          if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
          // A channel counts as done if it finished earlier or finishes now
          if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
            state    <= RESP;
            bready_q <= 1'b1;
          end
        end
        RESP: begin
          if (m_axi_bvalid) begin
            bready_q <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= resp_err | (m_axi_bid != ID_WIDTH'(STORE_ID));
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign st_ready      = (state == IDLE);
  assign st_done       = done_q;
  assign st_err        = err_q;

  assign m_axi_awid    = ID_WIDTH'(STORE_ID);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = {1'b0, size_q};
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awvalid = awvalid_q;

  assign m_axi_wdata   = data_q << {addr_q[OFF_W-1:0], 3'b000};
  assign m_axi_wstrb   = lane_mask << addr_q[OFF_W-1:0];
  assign m_axi_wlast   = wvalid_q;
  assign m_axi_wvalid  = wvalid_q;

  assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_axi_store_unit.sv
// Directed bench for axi_store_unit: hand-computed expectations checked with
// immediate assertions one cycle at a time.
module tb_axi_store_unit;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic [1:0]  st_size;
  logic        st_done;
  logic        st_err;
  logic [12:0] awid;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [12:0] bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int errors = 0;
  int checks = 0;

  axi_store_unit #(
    .ID_WIDTH  (13),
    .ADDR_WIDTH(64),
    .DATA_WIDTH(64),
    .STORE_ID  (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_size      (st_size),
    .st_done      (st_done),
    .st_err       (st_err),
    .m_axi_awid   (awid),
    .m_axi_awaddr (awaddr),
    .m_axi_awlen  (awlen),
    .m_axi_awsize (awsize),
    .m_axi_awburst(awburst),
    .m_axi_awlock (awlock),
    .m_axi_awcache(awcache),
    .m_axi_awprot (awprot),
    .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata  (wdata),
    .m_axi_wstrb  (wstrb),
    .m_axi_wlast  (wlast),
    .m_axi_wvalid (wvalid),
    .m_axi_wready (wready),
    .m_axi_bid    (bid),
    .m_axi_bresp  (bresp),
    .m_axi_bvalid (bvalid),
    .m_axi_bready (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b0; bid = '0; bresp = '0;
    #2;

    // Reset state and constant AXI fields
    chk("rst_st_ready", st_ready, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_st_done", st_done, 0);
    chk("rst_st_err", st_err, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("const_awid", awid, 1);
    chk("const_awlen", awlen, 0);
    chk("const_awburst", awburst, 2'b01);
    chk("const_awcache", {awlock, awcache, awprot}, 0);
    tick(); tick();

    // Dword store; release reset with request already pending
    reset = 1'b1;
    st_valid = 1'b1; st_addr = 64'h1000; st_data = 64'h1122334455667788; st_size = 2'd3;
    awready = 1'b1; wready = 1'b1;
    tick();
    chk("sync_no_accept_e1", awvalid, 0);
    chk("sync_ready_e1", st_ready, 1);
    tick();
    chk("d_awvalid", awvalid, 1);
    chk("d_wvalid", wvalid, 1);
    chk("d_wlast", wlast, 1);
    chk("d_awaddr", awaddr, 64'h1000);
    chk("d_wstrb", wstrb, 8'hFF);
    chk("d_wdata", wdata, 64'h1122334455667788);
    chk("d_awsize", awsize, 3);
    chk("d_st_ready", st_ready, 0);
    st_valid = 1'b0;
    tick();
    chk("d_bready", bready, 1);
    chk("d_aw_drop", awvalid, 0);
    chk("d_w_drop", wvalid, 0);
    chk("d_no_done_yet", st_done, 0);
    bvalid = 1'b1; bresp = 2'b00; bid = 13'd1;
    tick();
    chk("d_done", st_done, 1);
    chk("d_err", st_err, 0);
    chk("d_bready_off", bready, 0);
    bvalid = 1'b0;
    tick();
    chk("d_done_pulse", st_done, 0);

    // Byte store at lane 5; EXOKAY is not an error
    st_valid = 1'b1; st_addr = 64'h2005; st_data = 64'hAB; st_size = 2'd0;
    tick();
    chk("b_wstrb", wstrb, 8'h20);
    chk("b_wdata", wdata, 64'h0000AB0000000000);
    chk("b_awsize", awsize, 0);
    chk("b_awaddr", awaddr, 64'h2005);
    st_valid = 1'b0;
    tick();
    bvalid = 1'b1; bresp = 2'b01; bid = 13'd1;
    tick();
    chk("b_done", st_done, 1);
    chk("b_err", st_err, 0);
    bvalid = 1'b0;
    tick();

    // Misaligned word: no bus traffic, error two cycles after accept
    awready = 1'b0; wready = 1'b0;
    st_valid = 1'b1; st_addr = 64'h3002; st_data = 64'h55; st_size = 2'd2;
    tick();
    chk("m_awvalid0", awvalid, 0);
    chk("m_wvalid0", wvalid, 0);
    chk("m_done0", st_done, 0);
    chk("m_ready0", st_ready, 0);
    st_valid = 1'b0;
    tick();
    chk("m_done", st_done, 1);
    chk("m_err", st_err, 1);
    chk("m_awvalid1", awvalid, 0);
    chk("m_wvalid1", wvalid, 0);
    chk("m_ready1", st_ready, 1);
    tick();
    chk("m_done_pulse", st_done, 0);

    // Skewed ready: W at cycle 1, AW at cycle 5, SLVERR at cycle 8
    st_valid = 1'b1; st_addr = 64'h4004; st_data = 64'hDEADBEEF; st_size = 2'd2;
    tick();
    chk("s_wstrb", wstrb, 8'hF0);
    chk("s_wdata", wdata, 64'hDEADBEEF00000000);
    st_valid = 1'b0;
    wready = 1'b1;
    tick();
    chk("s_w_drop_c1", wvalid, 0);
    chk("s_aw_hold_c1", awvalid, 1);
    wready = 1'b0;
    bvalid = 1'b1; bresp = 2'b00; bid = 13'd1;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("s_aw_hold", awvalid, 1);
      chk("s_awaddr_stable", awaddr, 64'h4004);
      chk("s_bready_off", bready, 0);
      chk("s_bvalid_ignored", st_done, 0);
    end
    bvalid = 1'b0;
    awready = 1'b1;
    tick();
    chk("s_aw_drop_c5", awvalid, 0);
    chk("s_bready_c5", bready, 1);
    awready = 1'b0;
    tick(); tick();
    chk("s_wait_done", st_done, 0);
    chk("s_wait_bready", bready, 1);
    bvalid = 1'b1; bresp = 2'b10; bid = 13'd1;
    tick();
    chk("s_done", st_done, 1);
    chk("s_err", st_err, 1);
    bvalid = 1'b0; bresp = 2'b00;
    tick();

    // Reset while waiting for B, then a late response
    awready = 1'b1; wready = 1'b1;
    st_valid = 1'b1; st_addr = 64'h5000; st_data = 64'h77; st_size = 2'd3;
    tick();
    st_valid = 1'b0;
    tick();
    chk("r_in_resp", bready, 1);
    reset = 1'b0;
    #1;
    chk("r_bready_now", bready, 0);
    chk("r_ready_now", st_ready, 1);
    chk("r_awaddr_clr", awaddr, 0);
    tick();
    reset = 1'b1;
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = 2'b00; bid = 13'd1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("r_no_done", st_done, 0);
      chk("r_ready", st_ready, 1);
      chk("r_valids", {awvalid, wvalid, bready}, 0);
    end
    bvalid = 1'b0;
    tick();

    // Back-to-back: second request held while the first completes
    awready = 1'b1; wready = 1'b1;
    st_valid = 1'b1; st_addr = 64'h6006; st_data = 64'hBEEF; st_size = 2'd1;
    tick();
    chk("bb1_wstrb", wstrb, 8'hC0);
    chk("bb1_wdata", wdata, 64'hBEEF000000000000);
    chk("bb1_awaddr", awaddr, 64'h6006);
    st_addr = 64'h7000; st_data = 64'h0102030405060708; st_size = 2'd3;
    tick();
    chk("bb1_ready_busy", st_ready, 0);
    bvalid = 1'b1; bresp = 2'b00; bid = 13'd1;
    tick();
    chk("bb1_done", st_done, 1);
    chk("bb1_err", st_err, 0);
    chk("bb_ready_on_done", st_ready, 1);
    bvalid = 1'b0;
    tick();
    chk("bb2_accepted", awvalid, 1);
    chk("bb2_done_pulse", st_done, 0);
    chk("bb2_awaddr", awaddr, 64'h7000);
    chk("bb2_wstrb", wstrb, 8'hFF);
    chk("bb2_wdata", wdata, 64'h0102030405060708);
    st_valid = 1'b0;
    tick();
    bvalid = 1'b1; bresp = 2'b00; bid = 13'd3;
    tick();
    chk("bb2_done", st_done, 1);
    chk("bb2_bid_err", st_err, 1);
    bvalid = 1'b0;
    tick();
    chk("bb2_done_pulse_end", st_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
